// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO family.
// Status bit indices keep the previous 4-bit readback ordering {FULL, HALF, EMPTY, IDLE}.
package fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DEPTH = 8;
    localparam int unsigned FIFO_DEFAULT_WIDTH = 4;

    // Bit positions inside a packed 4-bit status word (MSB first: FULL, HALF, EMPTY, IDLE).
    localparam int unsigned FIFO_STAT_IDLE  = 0;
    localparam int unsigned FIFO_STAT_EMPTY = 1;
    localparam int unsigned FIFO_STAT_HALF  = 2;
    localparam int unsigned FIFO_STAT_FULL  = 3;
    localparam int unsigned FIFO_STAT_W     = 4;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width needed to hold an occupancy value from 0 to depth inclusive.
    function automatic int unsigned fifo_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// Simple dual-port storage for fifo_sync_param: one synchronous write port and
// one synchronous read port with an enabled, resettable output register.
module fifo_ram_sp
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = FIFO_DEFAULT_DEPTH,
    parameter int unsigned WIDTH  = FIFO_DEFAULT_WIDTH,
    parameter int unsigned ADDR_W = fifo_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    // Storage write; contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output word changes only when a read is accepted, otherwise it holds.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Registered read port with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: any depth 2..1024, registered read data with
// a valid strobe, and status flags that track the count in the same cycle.
// Optional sticky Overflow/Underflow flags with err_clr: define FIFO_ERR_FLAGS_EN.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH     = FIFO_DEFAULT_DEPTH,
    parameter int unsigned WIDTH     = FIFO_DEFAULT_WIDTH,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         EN,
    input  logic                         WR,
    input  logic                         RD,
    input  logic [WIDTH-1:0]             Data_in,
    output logic [WIDTH-1:0]             Data_out,
    output logic                         rd_valid,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Almost_full,
    output logic                         Almost_empty,
    output logic                         Half,
    output logic                         IDLE,
    output logic [fifo_cnt_w(DEPTH)-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic                         err_clr,
    output logic                         Overflow,
    output logic                         Underflow
`endif
);

    localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);
    localparam int unsigned CNT_W = fifo_cnt_w(DEPTH);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(DEPTH / 2);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_THRESH);

    if (DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be within 2..1024");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("fifo_sync_param: WIDTH must be within 1..64");
    end
    if (!(AE_THRESH >= 1 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("fifo_sync_param: need 1 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             half_q, half_d;
    logic             idle_q, idle_d;

    logic wr_acc;
    logic rd_acc;

    // Requests are qualified against the registered flags; blocked ones are dropped.
    always_comb begin
        wr_acc = EN & WR & ~full_q;
        rd_acc = EN & RD & ~empty_q;
    end

    // Next-state pointers, occupancy and flags. Flags are derived from the
    // next count so that they line up with count once registered.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        idle_d     = idle_q;
        rd_valid_d = rd_acc;

        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (EN) begin
            idle_d = ~(WR | RD);
        end

        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_C);
        aempty_d = (count_d <= AE_C);
        half_d   = (count_d >= HALF_C);
    end

    // Control state registers with synchronous reset taking priority over EN.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            half_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            half_q     <= half_d;
            idle_q     <= idle_d;
        end
    end

    // The write is gated by reset so a request on the reset edge leaves memory alone.
    fifo_ram_sp #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc & ~reset),
        .waddr (wr_ptr_q),
        .wdata (Data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (Data_out)
    );

    assign rd_valid     = rd_valid_q;
    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_full  = afull_q;
    assign Almost_empty = aempty_q;
    assign Half         = half_q;
    assign IDLE         = idle_q;
    assign count        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: a set in the same cycle as err_clr wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (EN & WR & full_q) begin
            overflow_d = 1'b1;
        end
        if (EN & RD & empty_q) begin
            underflow_d = 1'b1;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;
`endif

endmodule
